// File: rtl/miriscv_pkg.sv
// Shared definitions for the load/store unit: funct3 size codes, FSM state type
// and the alignment legality rule used by the LSU datapath.
package miriscv_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      LSU_IDLE = 2'd0,
      LSU_REQ  = 2'd1,
      LSU_RESP = 2'd2
   } lsu_state_e;

   // True when the size code is illegal or the address offset breaks natural alignment.
   function automatic logic lsu_access_bad(input logic [2:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         LDST_B, LDST_BU: bad = 1'b0;
         LDST_H, LDST_HU: bad = off[0];
         LDST_W:          bad = (off != 2'b00);
         default:         bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: byte enables, store replication, access legality
// and load-lane extraction with sign/zero extension.
module miriscv_lsu_align
   import miriscv_pkg::*;
(
   input  logic [2:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] wdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic        bad_o,
   input  logic [2:0]  ld_size_i,
   input  logic [1:0]  ld_off_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] ldata_o
);

   logic [7:0]  ld_byte_s;
   logic [15:0] ld_half_s;

   // Store-side byte enables and lane-replicated write data.
   always_comb begin
      be_o    = 4'b0000;
      wdata_o = 32'h0000_0000;
      bad_o   = lsu_access_bad(size_i, off_i);
      case (size_i)
         LDST_B, LDST_BU: begin
            be_o    = 4'b0001 << off_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         LDST_H, LDST_HU: begin
            be_o    = 4'b0011 << off_i;
            wdata_o = {2{wdata_i[15:0]}};
         end
         LDST_W: begin
            be_o    = 4'b1111;
            wdata_o = wdata_i;
         end
         default: begin
            be_o    = 4'b0000;
            wdata_o = 32'h0000_0000;
         end
      endcase
   end

   assign ld_byte_s = rdata_i[{ld_off_i, 3'b000} +: 8];
   assign ld_half_s = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

   // Load-side lane selection and extension.
   always_comb begin
      ldata_o = 32'h0000_0000;
      case (ld_size_i)
         LDST_B:  ldata_o = {{24{ld_byte_s[7]}}, ld_byte_s};
         LDST_BU: ldata_o = {24'h00_0000, ld_byte_s};
         LDST_H:  ldata_o = {{16{ld_half_s[15]}}, ld_half_s};
         LDST_HU: ldata_o = {16'h0000, ld_half_s};
         LDST_W:  ldata_o = rdata_i;
         default: ldata_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: IDLE/REQ/RESP handshake FSM with a transaction timeout,
// driving a word-addressed data bus and returning extended load data to the core.
module miriscv_lsu
   import miriscv_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        arstn_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_req_o,
   output logic        misaligned_o,
   output logic        bus_err_o,
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   lsu_state_e       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             data_req_q;
   logic             data_we_q;
   logic [3:0]       data_be_q;
   logic [31:0]      data_addr_q;
   logic [31:0]      data_wdata_q;
   logic             ld_we_q;
   logic [2:0]       ld_size_q;
   logic [1:0]       ld_off_q;

   logic [3:0]       be_s;
   logic [31:0]      wdata_s;
   logic             bad_s;
   logic [31:0]      ldata_s;
   logic             accept_s;
   logic             misal_s;
   logic             done_s;
   logic             tmo_s;

   miriscv_lsu_align u_align (
      .size_i    (lsu_size_i),
      .off_i     (lsu_addr_i[1:0]),
      .wdata_i   (lsu_data_i),
      .be_o      (be_s),
      .wdata_o   (wdata_s),
      .bad_o     (bad_s),
      .ld_size_i (ld_size_q),
      .ld_off_i  (ld_off_q),
      .rdata_i   (data_rdata_i),
      .ldata_o   (ldata_s)
   );

   // Release conditions; rvalid wins over a timeout landing in the same cycle.
   always_comb begin
      accept_s = (state_q == LSU_IDLE) && lsu_req_i && !bad_s;
      misal_s  = (state_q == LSU_IDLE) && lsu_req_i && bad_s;
      done_s   = (state_q == LSU_RESP) && data_rvalid_i;
      tmo_s    = (state_q != LSU_IDLE) && !done_s && (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   // Core-facing outputs, forced low while reset is asserted.
   always_comb begin
      lsu_stall_req_o = 1'b0;
      misaligned_o    = 1'b0;
      bus_err_o       = 1'b0;
      lsu_data_o      = 32'h0000_0000;
      if (!arstn_i) begin
         lsu_stall_req_o = lsu_req_i && !(done_s || misal_s || tmo_s);
         misaligned_o    = misal_s;
         bus_err_o       = tmo_s;
         lsu_data_o      = (done_s && !ld_we_q) ? ldata_s : 32'h0000_0000;
      end else begin
         lsu_stall_req_o = 1'b0;
      end
   end

   // Transaction FSM, timeout counter and registered bus outputs.
   always_ff @(posedge clk_i or posedge arstn_i) begin
      if (arstn_i) begin
         state_q      <= LSU_IDLE;
         cnt_q        <= '0;
         data_req_q   <= 1'b0;
         data_we_q    <= 1'b0;
         data_be_q    <= 4'b0000;
         data_addr_q  <= 32'h0000_0000;
         data_wdata_q <= 32'h0000_0000;
         ld_we_q      <= 1'b0;
         ld_size_q    <= 3'b000;
         ld_off_q     <= 2'b00;
      end else begin
         case (state_q)
            LSU_IDLE: begin
               if (accept_s) begin
                  state_q      <= LSU_REQ;
                  cnt_q        <= '0;
                  data_req_q   <= 1'b1;
                  data_we_q    <= lsu_we_i;
                  data_be_q    <= be_s;
                  data_addr_q  <= {lsu_addr_i[31:2], 2'b00};
                  data_wdata_q <= wdata_s;
                  ld_we_q      <= lsu_we_i;
                  ld_size_q    <= lsu_size_i;
                  ld_off_q     <= lsu_addr_i[1:0];
               end
            end
            LSU_REQ: begin
               if (tmo_s || data_gnt_i) begin
                  state_q      <= tmo_s ? LSU_IDLE : LSU_RESP;
                  cnt_q        <= tmo_s ? '0 : cnt_q + CNT_W'(1);
                  data_req_q   <= 1'b0;
                  data_we_q    <= 1'b0;
                  data_be_q    <= 4'b0000;
                  data_addr_q  <= 32'h0000_0000;
                  data_wdata_q <= 32'h0000_0000;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            LSU_RESP: begin
               if (done_s || tmo_s) begin
                  state_q <= LSU_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q    <= LSU_IDLE;
               cnt_q      <= '0;
               data_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign data_req_o   = data_req_q;
   assign data_we_o    = data_we_q;
   assign data_be_o    = data_be_q;
   assign data_addr_o  = data_addr_q;
   assign data_wdata_o = data_wdata_q;

endmodule

// File: tb/tb_miriscv_lsu.sv
// Scoreboard bench for miriscv_lsu: the driver queues expected bus requests and
// core responses, a negedge monitor pops and compares them as the DUT presents them.
module tb_miriscv_lsu;
   import miriscv_pkg::*;

   logic        clk_i = 1'b0;
   logic        arstn_i;
   logic        lsu_req_i;
   logic        lsu_we_i;
   logic [2:0]  lsu_size_i;
   logic [31:0] lsu_addr_i;
   logic [31:0] lsu_data_i;
   logic [31:0] lsu_data_o;
   logic        lsu_stall_req_o;
   logic        misaligned_o;
   logic        bus_err_o;
   logic        data_req_o;
   logic        data_we_o;
   logic [3:0]  data_be_o;
   logic [31:0] data_addr_o;
   logic [31:0] data_wdata_o;
   logic        data_gnt_i;
   logic        data_rvalid_i;
   logic [31:0] data_rdata_i;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      logic [31:0] data;
      logic        misal;
      logic        berr;
      logic [31:0] stalls;
   } rsp_t;

   req_t req_q[$];
   rsp_t rsp_q[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   stall_cnt = 0;

   miriscv_lsu #(.TIMEOUT(8)) dut (
      .clk_i           (clk_i),
      .arstn_i         (arstn_i),
      .lsu_req_i       (lsu_req_i),
      .lsu_we_i        (lsu_we_i),
      .lsu_size_i      (lsu_size_i),
      .lsu_addr_i      (lsu_addr_i),
      .lsu_data_i      (lsu_data_i),
      .lsu_data_o      (lsu_data_o),
      .lsu_stall_req_o (lsu_stall_req_o),
      .misaligned_o    (misaligned_o),
      .bus_err_o       (bus_err_o),
      .data_req_o      (data_req_o),
      .data_we_o       (data_we_o),
      .data_be_o       (data_be_o),
      .data_addr_o     (data_addr_o),
      .data_wdata_o    (data_wdata_o),
      .data_gnt_i      (data_gnt_i),
      .data_rvalid_i   (data_rvalid_i),
      .data_rdata_i    (data_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
      req_t r;
      r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
      req_q.push_back(r);
   endtask

   task automatic push_rsp(input logic [31:0] data, input logic misal, input logic berr,
                           input int stalls);
      rsp_t r;
      r.data = data; r.misal = misal; r.berr = berr; r.stalls = 32'(stalls);
      rsp_q.push_back(r);
   endtask

   // Drives one core access; the memory side grants after gdly and answers after rdly cycles.
   task automatic access(input logic we, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, input int gdly, input int rdly,
                         input logic [31:0] rdata);
      logic granted;
      logic in_resp;
      logic done;
      int   gcnt;
      int   rcnt;
      lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = sz; lsu_addr_i = addr; lsu_data_i = wd;
      data_rdata_i = rdata;
      in_resp = 1'b0; done = 1'b0; gcnt = 0; rcnt = 0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         data_gnt_i = data_req_o && (gcnt == gdly);
         if (data_req_o) gcnt++;
         data_rvalid_i = in_resp && (rcnt == rdly);
         if (in_resp) rcnt++;
         #1;
         done    = !lsu_stall_req_o;
         granted = data_req_o && data_gnt_i;
         @(posedge clk_i); #1;
         if (granted) in_resp = 1'b1;
      end
      if (!done) begin
         n_checks++;
         n_fails++;
         $display("FAIL access_bound: stall never released for addr 0x%08h", addr);
      end
      lsu_req_i = 1'b0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
   endtask

   // Scoreboard monitor, sampling mid-cycle.
   always @(negedge clk_i) begin
      if (arstn_i) begin
         check("reset_core_outs", {29'd0, lsu_stall_req_o, misaligned_o, bus_err_o}, 32'd0);
         check("reset_ldata", lsu_data_o, 32'd0);
         check("reset_bus", {27'd0, data_req_o, data_we_o, data_be_o} | data_addr_o | data_wdata_o,
               32'd0);
         stall_cnt = 0;
      end else begin
         if (data_req_o && data_gnt_i) begin
            if (req_q.size() == 0) begin
               check("unexpected_req", 32'd1, 32'd0);
            end else begin
               req_t r;
               r = req_q.pop_front();
               check("req_we", {31'd0, data_we_o}, {31'd0, r.we});
               check("req_be", {28'd0, data_be_o}, {28'd0, r.be});
               check("req_addr", data_addr_o, r.addr);
               check("req_wdata", data_wdata_o, r.wdata);
            end
         end
         if (!data_req_o) begin
            check("idle_bus_zero", {27'd0, data_we_o, data_be_o} | data_addr_o | data_wdata_o, 32'd0);
         end
         if (lsu_req_i && lsu_stall_req_o) begin
            stall_cnt++;
            check("stalled_outs_zero", {30'd0, misaligned_o, bus_err_o} | lsu_data_o, 32'd0);
         end else if (lsu_req_i) begin
            if (rsp_q.size() == 0) begin
               check("unexpected_release", 32'd1, 32'd0);
            end else begin
               rsp_t e;
               e = rsp_q.pop_front();
               check("rsp_data", lsu_data_o, e.data);
               check("rsp_misaligned", {31'd0, misaligned_o}, {31'd0, e.misal});
               check("rsp_bus_err", {31'd0, bus_err_o}, {31'd0, e.berr});
               check("rsp_stall_cycles", 32'(stall_cnt), e.stalls);
            end
            stall_cnt = 0;
         end else begin
            check("no_req_outs_zero",
                  {29'd0, lsu_stall_req_o, misaligned_o, bus_err_o} | lsu_data_o, 32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      arstn_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'd0;
      lsu_addr_i = 32'd0; lsu_data_i = 32'd0; data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
      data_rdata_i = 32'd0;
      repeat (3) @(posedge clk_i);
      #1;
      arstn_i = 1'b0;
      @(posedge clk_i); #1;

      // LB at 0x103, sign-extended top byte
      push_req(1'b0, 4'b1000, 32'h0000_0100, 32'h0);
      push_rsp(32'hFFFF_FF80, 1'b0, 1'b0, 2);
      access(1'b0, LDST_B, 32'h0000_0103, 32'h0, 0, 0, 32'h80FF_1234);

      // SH 0xABCD at 0x202, issued back-to-back
      push_req(1'b1, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD);
      push_rsp(32'h0, 1'b0, 1'b0, 2);
      access(1'b1, LDST_H, 32'h0000_0202, 32'h0000_ABCD, 0, 0, 32'h0);

      // LW misaligned at 0x006
      push_rsp(32'h0, 1'b1, 1'b0, 0);
      access(1'b0, LDST_W, 32'h0000_0006, 32'h0, 0, 0, 32'h0);

      // LHU at 0x10 with grant delayed three cycles
      push_req(1'b0, 4'b0011, 32'h0000_0010, 32'h0);
      push_rsp(32'h0000_F00D, 1'b0, 1'b0, 5);
      access(1'b0, LDST_HU, 32'h0000_0010, 32'h0, 3, 0, 32'h0000_F00D);

      // SB at 0x001, rvalid delayed two cycles
      push_req(1'b1, 4'b0010, 32'h0000_0000, 32'h3434_3434);
      push_rsp(32'h0, 1'b0, 1'b0, 4);
      access(1'b1, LDST_B, 32'h0000_0001, 32'h55AA_1234, 0, 2, 32'h0);

      // LH at 0x002, upper half sign-extended
      push_req(1'b0, 4'b1100, 32'h0000_0000, 32'h0);
      push_rsp(32'hFFFF_8001, 1'b0, 1'b0, 2);
      access(1'b0, LDST_H, 32'h0000_0002, 32'h0, 0, 0, 32'h8001_0000);

      // LBU at 0x7, zero-extended
      push_req(1'b0, 4'b1000, 32'h0000_0004, 32'h0);
      push_rsp(32'h0000_009A, 1'b0, 1'b0, 2);
      access(1'b0, LDST_BU, 32'h0000_0007, 32'h0, 0, 0, 32'h9A00_0000);

      // SW at 0x40
      push_req(1'b1, 4'b1111, 32'h0000_0040, 32'hDEAD_BEEF);
      push_rsp(32'h0, 1'b0, 1'b0, 2);
      access(1'b1, LDST_W, 32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 32'h0);

      // Illegal size code 3 and misaligned LH
      push_rsp(32'h0, 1'b1, 1'b0, 0);
      access(1'b0, 3'd3, 32'h0000_0000, 32'h0, 0, 0, 32'h0);
      push_rsp(32'h0, 1'b1, 1'b0, 0);
      access(1'b0, LDST_H, 32'h0000_0001, 32'h0, 0, 0, 32'h0);

      // LW with no grant: bus error in the 8th REQ cycle
      push_rsp(32'h0, 1'b0, 1'b1, 8);
      access(1'b0, LDST_W, 32'h0000_0080, 32'h0, 1000, 0, 32'h1111_1111);
      check("after_timeout_req", {31'd0, data_req_o}, 32'd0);

      // Late rvalid in IDLE must be ignored
      data_rvalid_i = 1'b1; data_rdata_i = 32'hFFFF_FFFF;
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b0;

      // LW that is reset while waiting in RESP
      push_req(1'b0, 4'b1111, 32'h0000_0300, 32'h0);
      lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_size_i = LDST_W; lsu_addr_i = 32'h0000_0300;
      lsu_data_i = 32'h0;
      @(posedge clk_i); #1;
      data_gnt_i = 1'b1;
      @(posedge clk_i); #1;
      data_gnt_i = 1'b0;
      arstn_i = 1'b1;
      #1;
      check("rst_mid_stall", {31'd0, lsu_stall_req_o}, 32'd0);
      check("rst_mid_req", {31'd0, data_req_o}, 32'd0);
      @(posedge clk_i); #1;
      arstn_i = 1'b0; lsu_req_i = 1'b0;
      data_rvalid_i = 1'b1; data_rdata_i = 32'hCAFE_F00D;
      @(posedge clk_i); #1;
      data_rvalid_i = 1'b0;

      // Normal LW after reset
      push_req(1'b0, 4'b1111, 32'h0000_0008, 32'h0);
      push_rsp(32'h1234_5678, 1'b0, 1'b0, 2);
      access(1'b0, LDST_W, 32'h0000_0008, 32'h0, 0, 0, 32'h1234_5678);

      repeat (3) @(posedge clk_i);
      #1;
      check("req_queue_drained", 32'(req_q.size()), 32'd0);
      check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/miriscv_lsu.md
MIRISCV_LSU -- requirements
Module: miriscv_lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum number of cycles spent in REQ+RESP before abort.
REQ-002 clk_i  in  1  clock; all state changes on its rising edge.
REQ-003 arstn_i  in  1  reset, asynchronous, active-high.
REQ-004 lsu_req_i  in  1  core requests a load/store; held stable while lsu_stall_req_o=1.
REQ-005 lsu_we_i  in  1  1=store, 0=load.
REQ-006 lsu_size_i  in  3  funct3 code: 0 B, 1 H, 2 W, 4 BU, 5 HU; other codes illegal.
REQ-007 lsu_addr_i  in  32  byte address.
REQ-008 lsu_data_i  in  32  store data; only the low byte/half is used for B/H.
REQ-009 lsu_data_o  out  32  extended load result.
REQ-010 lsu_stall_req_o  out  1  stall request to the core pipeline.
REQ-011 misaligned_o  out  1  one-cycle pulse when an access is misaligned or illegal.
REQ-012 bus_err_o  out  1  one-cycle pulse when an access times out.
REQ-013 data_req_o  out  1  memory request.
REQ-014 data_we_o  out  1  memory write enable.
REQ-015 data_be_o  out  4  byte enables.
REQ-016 data_addr_o  out  32  word address: {lsu_addr_i[31:2],2'b00}.
REQ-017 data_wdata_o  out  32  lane-replicated store data.
REQ-018 data_gnt_i  in  1  memory accepts the request.
REQ-019 data_rvalid_i  in  1  response valid; write acknowledge for stores.
REQ-020 data_rdata_i  in  32  read data.

Function
REQ-021 FSM states: IDLE, REQ, RESP.
- IDLE->REQ when lsu_req_i=1 and the access is aligned and legal.
- REQ->RESP when data_gnt_i=1.
- RESP->IDLE when data_rvalid_i=1.
REQ-022 data_req_o=1 only in REQ; data_we_o, data_be_o, data_addr_o and data_wdata_o are valid whenever data_req_o=1 and are 0 otherwise.
REQ-023 lsu_stall_req_o = lsu_req_i AND NOT(release), where release is any of:
- RESP with data_rvalid_i=1;
- a misaligned_o pulse;
- a bus_err_o pulse.
REQ-024 Minimum latency: request seen in cycle 0, data_req_o in cycle 1, gnt in cycle 1, rvalid in cycle 2, stall low in cycle 2; each extra wait cycle on gnt or rvalid adds one cycle.
REQ-025 Byte enables:
- B/BU: 4'b0001<<addr[1:0];
- H/HU: 4'b0011<<addr[1:0];
- W: 4'b1111.
REQ-026 data_wdata_o: B = {4{lsu_data_i[7:0]}}; H = {2{lsu_data_i[15:0]}}; W = lsu_data_i.
REQ-027 lsu_data_o is the selected lane of data_rdata_i, sign-extended for B/H and zero-extended for BU/HU/W, driven only in the release cycle of a load; it is 0 in every other cycle.
REQ-028 Misaligned or illegal access:
- misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0; illegal = size 3, 6 or 7;
- in IDLE: no memory request, misaligned_o=1 for one cycle, stall low that cycle, FSM stays IDLE.
REQ-029 Timeout:
- an 8-bit-minimum counter clears on IDLE->REQ and increments each cycle in REQ/RESP;
- on reaching TIMEOUT: bus_err_o pulses, FSM goes to IDLE, stall releases, lsu_data_o=0;
- a late rvalid arriving while in IDLE is ignored.
REQ-030 Back-to-back: a new lsu_req_i in the cycle after a release is accepted from IDLE with no bubble beyond REQ-024.
REQ-031 data_rvalid_i in IDLE or REQ, and data_gnt_i outside REQ, shall be ignored.

Reset
REQ-032 arstn_i=1, at any time including mid-transaction, forces IDLE and counter=0, and holds every output at 0 until release.
REQ-033 The first request after reset release is handled normally; no outstanding transaction is remembered.

Structure
REQ-034 Package miriscv_pkg holds the size-code localparams (LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU) and the LSU state enum typedef.
REQ-035 A combinational sub-module miriscv_lsu_align computes be, wdata, load extraction/extension and the misaligned/illegal flag; the FSM and counter stay in miriscv_lsu.

Verification
REQ-036 LB at 0x103, rdata=0x80FF_1234, gnt and rvalid immediate -> be=0001 (shifted to 1000), lsu_data_o=0xFFFF_FF80, stall high for 2 cycles.
REQ-037 SH data 0x0000_ABCD at 0x202 -> be=1100, wdata=0xABCD_ABCD, addr=0x200, we=1.
REQ-038 LW at 0x006 -> no data_req_o, misaligned_o one cycle, stall low the same cycle.
REQ-039 LHU at 0x10, gnt delayed 3 cycles, rdata=0x0000_F00D -> lsu_data_o=0x0000_F00D, stall high 5 cycles.
REQ-040 TIMEOUT=8, gnt never asserted -> bus_err_o pulses in the 8th REQ cycle, FSM IDLE next cycle.
REQ-041 arstn_i pulsed while in RESP -> all outputs 0 and FSM IDLE; a later rvalid is ignored and the next LW completes normally.
